// File: rtl/maj_net_seq_pkg.sv
// Shared types and constants for the majority-network sequencer:
// operand select encoding, node program record, FSM states and the reset program.
package maj_net_seq_pkg;

    localparam int MAX_NODES = 8;

    localparam logic [3:0] SEL_ZERO = 4'd0;
    localparam logic [3:0] SEL_X0   = 4'd1;
    localparam logic [3:0] SEL_W0   = 4'd8;

    typedef struct packed {
        logic       inv_c;
        logic       inv_b;
        logic       inv_a;
        logic [3:0] sel_c;
        logic [3:0] sel_b;
        logic [3:0] sel_a;
    } node_cfg_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [3:0] sel_x(input int idx);
        return SEL_X0 + 4'(idx);
    endfunction

    function automatic logic [3:0] sel_w(input int idx);
        return SEL_W0 + 4'(idx);
    endfunction

    function automatic node_cfg_t mk_node(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] c);
        node_cfg_t n;
        n       = '0;
        n.sel_a = a;
        n.sel_b = b;
        n.sel_c = c;
        return n;
    endfunction

    localparam node_cfg_t DEFAULT_PROG [MAX_NODES] = '{
        mk_node(sel_x(0), sel_x(1), sel_x(5)),
        mk_node(sel_x(0), sel_x(2), sel_x(4)),
        mk_node(sel_x(1), sel_x(3), sel_w(1)),
        mk_node(sel_x(0), sel_x(4), sel_x(5)),
        mk_node(sel_x(2), sel_x(6), sel_w(3)),
        mk_node(sel_w(0), sel_w(2), sel_w(4)),
        mk_node(SEL_ZERO, SEL_ZERO, SEL_ZERO),
        mk_node(SEL_ZERO, SEL_ZERO, SEL_ZERO)
    };

endpackage

// File: rtl/maj_net_sequencer_maj3.sv
// Three-input majority gate, the single shared evaluation unit of the sequencer.
module maj3_unit (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);

    assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/maj_net_sequencer.sv
// Programmable majority-network evaluator: one node per cycle through a shared MAJ3.
// Define MAJ_NET_SEQ_INV_EN to enable per-operand complemented edges.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | ready for a vector; program writes allowed
// ST_EVAL | node k evaluated and registered each cycle
// ST_DONE | result presented, held until out_ready
module maj_net_sequencer
    import maj_net_seq_pkg::*;
#(
    parameter int NUM_NODES = 6,
    parameter int NUM_IN    = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NUM_IN-1:0] in_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out,
    output logic              busy,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_addr,
    input  logic [14:0]       cfg_data
);

    localparam logic [2:0]           LAST   = 3'(NUM_NODES - 1);
    localparam logic [MAX_NODES-1:0] W_MASK = 8'((1 << NUM_NODES) - 1);

    state_t              state;
    state_t              state_nxt;
    logic [2:0]          k;
    logic [NUM_IN-1:0]   x_reg;
    logic [MAX_NODES-1:0] w;
    logic [11:0]         sel_mem [MAX_NODES];
    logic                accept;
    logic                eval_en;
    logic                cfg_wr;
    node_cfg_t           cfg_in;
    logic [15:0]         src;
    logic [11:0]         cur_sel;
    logic                op_a;
    logic                op_b;
    logic                op_c;
    logic                maj_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        eval_en   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_EVAL;
                end
            end
            ST_EVAL: begin
                busy    = 1'b1;
                eval_en = 1'b1;
                if (k == LAST) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Program is frozen for the whole transaction, including the accepting cycle.
    assign cfg_in = node_cfg_t'(cfg_data);
    assign cfg_wr = cfg_we && (state == ST_IDLE) && !accept && (cfg_addr <= LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_NODES; i++) begin
                sel_mem[i] <= {DEFAULT_PROG[i].sel_c, DEFAULT_PROG[i].sel_b,
                               DEFAULT_PROG[i].sel_a};
            end
        end else if (cfg_wr) begin
            sel_mem[cfg_addr] <= {cfg_in.sel_c, cfg_in.sel_b, cfg_in.sel_a};
        end
    end

    // Node registers above NUM_NODES-1 are masked so such selects read 0.
    assign src     = {w & W_MASK, x_reg, 1'b0};
    assign cur_sel = sel_mem[k];

`ifdef MAJ_NET_SEQ_INV_EN
    logic [2:0] inv_mem [MAX_NODES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_NODES; i++) begin
                inv_mem[i] <= {DEFAULT_PROG[i].inv_c, DEFAULT_PROG[i].inv_b,
                               DEFAULT_PROG[i].inv_a};
            end
        end else if (cfg_wr) begin
            inv_mem[cfg_addr] <= {cfg_in.inv_c, cfg_in.inv_b, cfg_in.inv_a};
        end
    end

    assign op_a = src[cur_sel[3:0]]  ^ inv_mem[k][0];
    assign op_b = src[cur_sel[7:4]]  ^ inv_mem[k][1];
    assign op_c = src[cur_sel[11:8]] ^ inv_mem[k][2];
`else
    logic unused_inv;
    assign unused_inv = ^{cfg_in.inv_c, cfg_in.inv_b, cfg_in.inv_a};

    assign op_a = src[cur_sel[3:0]];
    assign op_b = src[cur_sel[7:4]];
    assign op_c = src[cur_sel[11:8]];
`endif

    maj3_unit u_maj3 (
        .a (op_a),
        .b (op_b),
        .c (op_c),
        .y (maj_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k     <= '0;
            x_reg <= '0;
            w     <= '0;
        end else if (accept) begin
            k     <= '0;
            x_reg <= in_x;
            w     <= '0;
        end else if (eval_en) begin
            w[k] <= maj_y;
            k    <= (k == LAST) ? 3'd0 : k + 3'd1;
        end
    end

    assign out = w[LAST];

endmodule

// File: tb/tb_maj_net_sequencer.sv
// Bench for maj_net_sequencer: vector table plus corner sequences, results
// checked through an expected-value queue and a small network model.
module tb_maj_net_sequencer;

    localparam int N = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        cfg_we = 1'b0;
    logic [6:0]  in_x = '0;
    logic [2:0]  cfg_addr = '0;
    logic [14:0] cfg_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic        out;
    logic        busy;

    int   tests = 0;
    int   fails = 0;
    logic exp_q[$];
    logic [14:0] tb_prog [8];

    typedef struct {
        logic [6:0] x;
        logic       exp;
    } vec_t;
    vec_t vecs [7];

    always #5 clk = ~clk;

    maj_net_sequencer #(.NUM_NODES(N), .NUM_IN(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data)
    );

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_default_model();
        tb_prog[0] = 15'h0621;
        tb_prog[1] = 15'h0531;
        tb_prog[2] = 15'h0942;
        tb_prog[3] = 15'h0651;
        tb_prog[4] = 15'h0B73;
        tb_prog[5] = 15'h0CA8;
        tb_prog[6] = 15'h0000;
        tb_prog[7] = 15'h0000;
    endtask

    function automatic logic model_eval(input logic [6:0] x);
        logic [7:0]  wv;
        logic [2:0]  v;
        logic [14:0] e;
        int          s;
        wv = '0;
        for (int n = 0; n < N; n++) begin
            e = tb_prog[n];
            for (int o = 0; o < 3; o++) begin
                s = int'(4'(e >> (4 * o)));
                if (s == 0)          v[o] = 1'b0;
                else if (s < 8)      v[o] = 1'(x >> (s - 1));
                else if (s - 8 < N)  v[o] = 1'(wv >> (s - 8));
                else                 v[o] = 1'b0;
`ifdef MAJ_NET_SEQ_INV_EN
                v[o] = v[o] ^ 1'(e >> (12 + o));
`endif
            end
            if ((v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2])) wv = wv | (8'd1 << n);
        end
        return wv[N-1];
    endfunction

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cfg_we    = 1'b0;
        rst_n     = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        load_default_model();
        cyc();
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [14:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        cyc();
        cfg_we = 1'b0;
        if (int'(a) < N) tb_prog[a] = d;
    endtask

    // inject_at: -1 none, 0 program write alongside acceptance, >0 write at that EVAL cycle
    task automatic run_txn(input logic [6:0] x, input logic exp, input int hold,
                           input int inject_at);
        int   c;
        logic e;
        c = 0;
        while (!in_ready && c < 20) begin
            cyc();
            c++;
        end
        check_bit("ready_before", in_ready, 1'b1);
        in_valid = 1'b1;
        in_x     = x;
        exp_q.push_back(exp);
        if (inject_at == 0) begin
            cfg_we   = 1'b1;
            cfg_addr = 3'd5;
            cfg_data = 15'h0000;
        end
        cyc();
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        check_bit("busy_eval", busy, 1'b1);
        c = 0;
        while (!out_valid && c < 40) begin
            if (inject_at > 0 && c == inject_at) begin
                cfg_we   = 1'b1;
                cfg_addr = 3'd5;
                cfg_data = 15'h0000;
            end
            cyc();
            cfg_we = 1'b0;
            c++;
        end
        check_int("latency", c, N);
        check_bit("ready_done", in_ready, 1'b0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_x     = ~x;
            cyc();
            check_bit("hold_valid", out_valid, 1'b1);
            check_bit("hold_out", out, exp);
            check_bit("hold_ready", in_ready, 1'b0);
            check_bit("hold_busy", busy, 1'b1);
        end
        in_valid = 1'b0;
        check_int("sb_depth", exp_q.size(), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_bit("out", out, e);
        end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        check_bit("valid_drop", out_valid, 1'b0);
        check_bit("idle_ready", in_ready, 1'b1);
        check_bit("idle_busy", busy, 1'b0);
    endtask

    initial begin
        logic [6:0] rx;

        vecs[0] = '{7'b0100011, 1'b0};
        vecs[1] = '{7'h7F,      1'b1};
        vecs[2] = '{7'h00,      1'b0};
        vecs[3] = '{7'b0010101, 1'b0};
        vecs[4] = '{7'b1011110, 1'b1};
        vecs[5] = '{7'b0110011, 1'b1};
        vecs[6] = '{7'b1000100, 1'b0};

        do_reset();
        check_bit("rst_in_ready", in_ready, 1'b1);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_out", out, 1'b0);

        for (int i = 0; i < 7; i++) run_txn(vecs[i].x, vecs[i].exp, 0, -1);

        run_txn(7'h7F, 1'b1, 5, -1);

        for (int i = 0; i < 6; i++) begin
            rx = 7'($urandom_range(0, 127));
            run_txn(rx, model_eval(rx), 0, -1);
        end

        cfg_write(3'd5, 15'h0011);
        cfg_write(3'd6, 15'h0000);
        run_txn(7'h01, 1'b1, 0, -1);
        run_txn(7'h7E, 1'b0, 0, -1);

        run_txn(7'h01, 1'b1, 0, 2);
        run_txn(7'h01, 1'b1, 0, -1);
        run_txn(7'h01, 1'b1, 0, 0);
        run_txn(7'h01, 1'b1, 0, -1);

        for (int i = 0; i < 4; i++) begin
            rx = 7'($urandom_range(0, 127));
            run_txn(rx, model_eval(rx), 0, -1);
        end

        in_valid = 1'b1;
        in_x     = 7'h01;
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        cyc();
        rst_n = 1'b0;
        #2;
        check_bit("rst_eval_valid", out_valid, 1'b0);
        check_bit("rst_eval_busy", busy, 1'b0);
        cyc();
        rst_n = 1'b1;
        load_default_model();
        cyc();
        check_bit("rst_eval_ready", in_ready, 1'b1);
        run_txn(7'h01, 1'b0, 0, -1);

        cfg_write(3'd5, 15'h0011);
        in_valid = 1'b1;
        in_x     = 7'h01;
        cyc();
        in_valid = 1'b0;
        for (int i = 0; i < 40 && !out_valid; i++) cyc();
        check_bit("done_reached", out_valid, 1'b1);
        rst_n = 1'b0;
        #2;
        check_bit("rst_done_valid", out_valid, 1'b0);
        check_bit("rst_done_out", out, 1'b0);
        check_bit("rst_done_busy", busy, 1'b0);
        cyc();
        rst_n = 1'b1;
        load_default_model();
        cyc();
        run_txn(7'h01, 1'b0, 0, -1);

        cfg_write(3'd5, 15'h1000);
        run_txn(7'h7F, 1'b0, 0, -1);
        cfg_write(3'd5, 15'h3000);
`ifdef MAJ_NET_SEQ_INV_EN
        run_txn(7'h00, 1'b1, 0, -1);
`else
        run_txn(7'h00, 1'b0, 0, -1);
`endif

        cfg_write(3'd5, 15'h0CA8);
        cfg_write(3'd3, 15'h592D);
        for (int i = 0; i < 4; i++) begin
            rx = 7'($urandom_range(0, 127));
            run_txn(rx, model_eval(rx), 0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/maj_net_sequencer.md
MAJ_NET_SEQUENCER -- requirements
Module: maj_net_sequencer

Interface
REQ-001 SHALL have parameter NUM_NODES, default 6, number of majority nodes in the program (2..8).
REQ-002 SHALL have parameter NUM_IN, default 7, number of primary inputs (fixed 7 in this release).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  input vector offered.
REQ-006 SHALL have port in_ready  output  1  block can accept a vector.
REQ-007 SHALL have port in_x  input  7  primary inputs, bit i = x_i.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port out  output  1  network result, the value of node NUM_NODES-1.
REQ-011 SHALL have port busy  output  1  high in EVAL or DONE.
REQ-012 SHALL have port cfg_we  input  1  program write strobe.
REQ-013 SHALL have port cfg_addr  input  3  node index to write.
REQ-014 SHALL have port cfg_data  input  15  {inv_c, inv_b, inv_a, sel_c[3:0], sel_b[3:0], sel_a[3:0]}.

Function
REQ-015 SHALL evaluate each node as MAJ(a,b,c) = ab | ac | bc, using one shared 3-input majority unit, one node per cycle.
REQ-016 SHALL decode operand selects as: 0 = constant 0; 1..7 = x0..x6; 8..15 = node register w0..w7. A node select beyond NUM_NODES-1 SHALL read 0.
REQ-017 SHALL implement FSM IDLE -> EVAL -> DONE -> IDLE.
REQ-018 IDLE: in_ready=1; on in_valid & in_ready, SHALL capture in_x, clear all node registers to 0, set node index k=0, and go to EVAL.
REQ-019 EVAL: in_ready=0; SHALL write MAJ of node k's operands into w_k each cycle and increment k; after writing node NUM_NODES-1, SHALL go to DONE.
REQ-020 A forward or self reference (select w_j with j>=k) SHALL read the current register value, which is 0 for the current transaction.
REQ-021 Latency: with acceptance at edge 0, node k SHALL be registered at edge k+1, and out_valid SHALL be high from edge NUM_NODES.
REQ-022 DONE: out_valid=1 and out=w_{NUM_NODES-1}, both held stable until out_ready=1; on out_valid & out_ready, SHALL go to IDLE with out_valid=0 on the next cycle.
REQ-023 in_ready SHALL be 0 in DONE; there is no overlap between transactions.
REQ-024 cfg_we in IDLE without a simultaneous input acceptance SHALL write cfg_data into node cfg_addr; writes to cfg_addr >= NUM_NODES SHALL be ignored.
REQ-025 cfg_we in EVAL or DONE, or in the same cycle as an input acceptance, SHALL be ignored (the program is stable during a transaction).

Reset
REQ-026 On rst_n=0, SHALL asynchronously set state=IDLE, in_ready=1 after release, out_valid=0, out=0, busy=0, k=0, captured inputs and node registers to 0.
REQ-027 On reset, the program SHALL load the default program: w0=MAJ(x0,x1,x5), w1=MAJ(x0,x2,x4), w2=MAJ(x1,x3,w1), w3=MAJ(x0,x4,x5), w4=MAJ(x2,x6,w3), w5=MAJ(w0,w2,w4); nodes 6 and 7 = MAJ(0,0,0); all invert bits 0.
REQ-028 Reset asserted in mid-EVAL or mid-DONE SHALL discard the transaction with no output produced.

Configuration
REQ-029 With MAJ_NET_SEQ_INV_EN defined, operand invert bits SHALL complement the selected operand before the majority (complemented edges); inverting constant 0 yields 1.
REQ-030 Without MAJ_NET_SEQ_INV_EN, the invert bits SHALL be accepted but ignored, and not stored.

Structure
REQ-031 Package maj_net_seq_pkg SHALL hold the select encoding constants, the node_cfg_t struct (sels + inverts), the FSM state enum, and the default program constant.
REQ-032 The majority function SHALL be a sub-module maj3_unit (combinational a,b,c -> y), instantiated once.

Verification
REQ-033 After reset, in_x=7'b0100011 (x0,x1,x5=1) -> out_valid rises 6 cycles after acceptance, out=0.
REQ-034 Default program: in_x=7'h7F -> out=1; in_x=7'h00 -> out=0.
REQ-035 Hold out_ready=0 for 5 cycles in DONE -> out_valid and out stay stable, in_ready=0, and a new in_valid is not accepted.
REQ-036 In IDLE, write node 5 = MAJ(x0,x0,0) -> in_x=7'h01 gives out=1, and in_x=7'h7E gives out=0.
REQ-037 Issue cfg_we to node 5 during EVAL -> the write is ignored, and the next transaction uses the previous program.
REQ-038 Assert rst_n=0 at EVAL cycle 3 -> out_valid=0, busy=0, default program restored; with MAJ_NET_SEQ_INV_EN, node 5 = MAJ(~0,0,0) gives out=0, and MAJ(~0,~0,0) gives out=1.
